// File: rtl/cpu_pkg.sv
// Shared definitions for the 4-bit microcoded CPU:
// control-word bit map, ALU select width and phase encodings.
package cpu_pkg;

    localparam int CW_W         = 13;
    localparam int CW_INCPC     = 12;
    localparam int CW_LOADPC    = 11;
    localparam int CW_LOADA     = 10;
    localparam int CW_LOADFLAGS = 9;
    localparam int CW_S_HI      = 8;
    localparam int CW_S_LO      = 6;
    localparam int CW_CSRAM     = 5;
    localparam int CW_WERAM     = 4;
    localparam int CW_OEALU     = 3;
    localparam int CW_OEIN      = 2;
    localparam int CW_OEOPRND   = 1;
    localparam int CW_LOADOUT   = 0;

    localparam int ALU_SEL_W = CW_S_HI - CW_S_LO + 1;

    typedef enum logic {
        PH_FETCH = 1'b0,
        PH_EXEC  = 1'b1
    } phase_t;

endpackage

// File: rtl/uc_sequencer_pc_counter.sv
// Program counter register: load beats increment,
// both gated by enable, asynchronous active-high reset.
module pc_counter #(
    parameter int PC_W = 12
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic            load,
    input  logic            inc,
    input  logic [PC_W-1:0] d,
    output logic [PC_W-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (en) begin
            if (load) begin
                q <= d;
            end else if (inc) begin
                q <= q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uc_sequencer.sv
// Fetch/execute sequencer: PC, phase, fetch register and flags,
// microcode address generation and enable-gated datapath strobes.
import cpu_pkg::*;

module uc_sequencer #(
    parameter int PC_W = 12,
    parameter int CW_W = cpu_pkg::CW_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic [7:0]           prog_data,
    input  logic [CW_W-1:0]      ctrl,
    input  logic                 alu_c,
    input  logic                 alu_z,
    output logic [PC_W-1:0]      prog_addr,
    output logic [6:0]           uc_addr,
    output logic                 phase,
    output logic [3:0]           instr,
    output logic [3:0]           oprnd,
    output logic                 flag_c,
    output logic                 flag_z,
    output logic [ALU_SEL_W-1:0] alu_sel,
    output logic                 load_a,
    output logic                 ram_cs,
    output logic                 ram_we,
    output logic                 oe_alu,
    output logic                 oe_in,
    output logic                 oe_oprnd,
    output logic                 load_out
);

    phase_t          ph_q;
    logic [PC_W-1:0] jump_tgt;

    // Jump target: operand latched at fetch plus second program byte.
    assign jump_tgt = PC_W'({oprnd, prog_data});

    pc_counter #(
        .PC_W(PC_W)
    ) u_pc (
        .clk  (clk),
        .reset(reset),
        .en   (en),
        .load (ctrl[CW_LOADPC]),
        .inc  (ctrl[CW_INCPC]),
        .d    (jump_tgt),
        .q    (prog_addr)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ph_q   <= PH_FETCH;
            instr  <= '0;
            oprnd  <= '0;
            flag_c <= 1'b0;
            flag_z <= 1'b0;
        end else if (en) begin
            ph_q <= (ph_q == PH_FETCH) ? PH_EXEC : PH_FETCH;
            if (ph_q == PH_FETCH) begin
                {instr, oprnd} <= prog_data;
            end
            if (ctrl[CW_LOADFLAGS]) begin
                flag_c <= alu_c;
                flag_z <= alu_z;
            end
        end
    end

    assign phase   = ph_q;
    assign uc_addr = {instr, flag_c, flag_z, phase};
    assign alu_sel = ctrl[CW_S_HI:CW_S_LO];

    assign load_a   = en & ctrl[CW_LOADA];
    assign ram_cs   = en & ctrl[CW_CSRAM];
    assign ram_we   = en & ctrl[CW_WERAM];
    assign oe_alu   = en & ctrl[CW_OEALU];
    assign oe_in    = en & ctrl[CW_OEIN];
    assign oe_oprnd = en & ctrl[CW_OEOPRND];
    assign load_out = en & ctrl[CW_LOADOUT];

endmodule

// File: tb/tb_uc_sequencer.sv
// Directed bench for uc_sequencer: stimulus pushes hand-computed
// expectations into a queue, a monitor pops and compares them.
module tb_uc_sequencer;

    logic        clk;
    logic        reset;
    logic        en;
    logic [7:0]  prog_data;
    logic [12:0] ctrl;
    logic        alu_c;
    logic        alu_z;
    logic [11:0] prog_addr;
    logic [6:0]  uc_addr;
    logic        phase;
    logic [3:0]  instr;
    logic [3:0]  oprnd;
    logic        flag_c;
    logic        flag_z;
    logic [2:0]  alu_sel;
    logic        load_a;
    logic        ram_cs;
    logic        ram_we;
    logic        oe_alu;
    logic        oe_in;
    logic        oe_oprnd;
    logic        load_out;

    uc_sequencer dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .prog_data(prog_data),
        .ctrl     (ctrl),
        .alu_c    (alu_c),
        .alu_z    (alu_z),
        .prog_addr(prog_addr),
        .uc_addr  (uc_addr),
        .phase    (phase),
        .instr    (instr),
        .oprnd    (oprnd),
        .flag_c   (flag_c),
        .flag_z   (flag_z),
        .alu_sel  (alu_sel),
        .load_a   (load_a),
        .ram_cs   (ram_cs),
        .ram_we   (ram_we),
        .oe_alu   (oe_alu),
        .oe_in    (oe_in),
        .oe_oprnd (oe_oprnd),
        .load_out (load_out)
    );

    typedef struct {
        string       name;
        logic [11:0] pc;
        logic        ph;
        logic [3:0]  ins;
        logic [3:0]  op;
        logic        c;
        logic        z;
        logic [6:0]  stb;
        logic [2:0]  sel;
    } exp_t;

    exp_t q[$];
    event obs;
    int   n_chk  = 0;
    int   n_pass = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string nm, input string fld,
                       input int act, input int want);
        n_chk++;
        if (act == want) n_pass++;
        else $display("FAIL %s.%s actual=%0h required=%0h",
                      nm, fld, act, want);
    endtask

    // Monitor: compares every presented expectation with DUT outputs.
    initial begin
        exp_t e;
        logic [6:0] act_stb;
        forever begin
            @(obs);
            while (q.size() > 0) begin
                e = q.pop_front();
                act_stb = {load_a, ram_cs, ram_we, oe_alu,
                           oe_in, oe_oprnd, load_out};
                cmp(e.name, "pc", int'(prog_addr), int'(e.pc));
                cmp(e.name, "phase", int'(phase), int'(e.ph));
                cmp(e.name, "instr", int'(instr), int'(e.ins));
                cmp(e.name, "oprnd", int'(oprnd), int'(e.op));
                cmp(e.name, "flag_c", int'(flag_c), int'(e.c));
                cmp(e.name, "flag_z", int'(flag_z), int'(e.z));
                cmp(e.name, "uc_addr", int'(uc_addr),
                    int'({e.ins, e.c, e.z, e.ph}));
                cmp(e.name, "strobes", int'(act_stb), int'(e.stb));
                cmp(e.name, "alu_sel", int'(alu_sel), int'(e.sel));
            end
        end
    end

    task automatic expect_st(input string nm, input logic [11:0] pc,
                             input logic ph, input logic [3:0] ins,
                             input logic [3:0] op, input logic c,
                             input logic z);
        exp_t e;
        e.name = nm;
        e.pc   = pc;
        e.ph   = ph;
        e.ins  = ins;
        e.op   = op;
        e.c    = c;
        e.z    = z;
        e.stb  = en ? {ctrl[10], ctrl[5], ctrl[4], ctrl[3],
                       ctrl[2], ctrl[1], ctrl[0]} : 7'b0;
        e.sel  = ctrl[8:6];
        q.push_back(e);
        -> obs;
        #1;
    endtask

    task automatic drive(input logic e, input logic [7:0] pd,
                         input logic [12:0] cw, input logic ac,
                         input logic az);
        en        = e;
        prog_data = pd;
        ctrl      = cw;
        alu_c     = ac;
        alu_z     = az;
    endtask

    task automatic step(input logic e, input logic [7:0] pd,
                        input logic [12:0] cw, input logic ac,
                        input logic az);
        drive(e, pd, cw, ac, az);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        drive(1'b1, 8'h5A, 13'h1008, 1'b0, 1'b0);
        #2;
        expect_st("reset", 12'h000, 0, 4'h0, 4'h0, 0, 0);
        #3;
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        #2;
        reset = 1'b0;
        #1;

        step(1, 8'h5A, 13'h1008, 0, 0);
        expect_st("fetch1", 12'h001, 1, 4'h5, 4'hA, 0, 0);
        step(1, 8'h00, 13'h1008, 0, 0);
        expect_st("exec1", 12'h002, 0, 4'h5, 4'hA, 0, 0);
        step(1, 8'h23, 13'h1000, 0, 0);
        expect_st("fetch2", 12'h003, 1, 4'h2, 4'h3, 0, 0);
        step(1, 8'h4C, 13'h0808, 0, 0);
        expect_st("jump", 12'h34C, 0, 4'h2, 4'h3, 0, 0);
        step(1, 8'h23, 13'h1000, 0, 0);
        expect_st("fetch3", 12'h34D, 1, 4'h2, 4'h3, 0, 0);
        step(1, 8'h4C, 13'h1808, 0, 0);
        expect_st("jump_prio", 12'h34C, 0, 4'h2, 4'h3, 0, 0);

        step(1, 8'h23, 13'h1000, 0, 0);
        expect_st("fetch4", 12'h34D, 1, 4'h2, 4'h3, 0, 0);
        step(1, 8'h00, 13'h1200, 1, 0);
        expect_st("flags", 12'h34E, 0, 4'h2, 4'h3, 1, 0);
        step(1, 8'h70, 13'h1000, 0, 1);
        expect_st("fetch_fl", 12'h34F, 1, 4'h7, 4'h0, 1, 0);

        for (int i = 0; i < 3; i++) begin
            step(0, 8'h99, 13'h1FFF, 0, 1);
            expect_st($sformatf("freeze%0d", i),
                      12'h34F, 1, 4'h7, 4'h0, 1, 0);
        end
        drive(1, 8'h99, 13'h1FFF, 0, 1);
        #1;
        expect_st("unfreeze", 12'h34F, 1, 4'h7, 4'h0, 1, 0);
        step(1, 8'h00, 13'h1000, 0, 0);
        expect_st("exec_uf", 12'h350, 0, 4'h7, 4'h0, 1, 0);

        step(1, 8'h2F, 13'h1000, 0, 0);
        expect_st("fetch5", 12'h351, 1, 4'h2, 4'hF, 1, 0);
        step(1, 8'hFF, 13'h0800, 0, 0);
        expect_st("jump_fff", 12'hFFF, 0, 4'h2, 4'hF, 1, 0);
        step(1, 8'h00, 13'h1008, 0, 0);
        expect_st("wrap", 12'h000, 1, 4'h0, 4'h0, 1, 0);

        step(1, 8'h00, 13'h1000, 0, 0);
        expect_st("exec6", 12'h001, 0, 4'h0, 4'h0, 1, 0);
        step(1, 8'h21, 13'h1000, 0, 0);
        expect_st("fetch6", 12'h002, 1, 4'h2, 4'h1, 1, 0);
        step(1, 8'h22, 13'h0800, 0, 0);
        expect_st("jump122", 12'h122, 0, 4'h2, 4'h1, 1, 0);
        step(1, 8'h00, 13'h1000, 0, 0);
        expect_st("at123", 12'h123, 1, 4'h0, 4'h0, 1, 0);

        #2;
        reset = 1'b1;
        #1;
        expect_st("areset", 12'h000, 0, 4'h0, 4'h0, 0, 0);
        #1;
        reset = 1'b0;
        #1;
        expect_st("released", 12'h000, 0, 4'h0, 4'h0, 0, 0);
        step(1, 8'h5A, 13'h1000, 0, 0);
        expect_st("refetch", 12'h001, 1, 4'h5, 4'hA, 0, 0);

        #5;
        n_chk++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL drain pending=%0d required=0", q.size());

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
